// File: rtl/exec_ctrl_alu_pkg.sv
// Shared constants for the execute stage: opcodes, ALU-class encodings, ALU operation codes.
package exec_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_REM = 4'b1011;

  // funct3 map shared by R-type (funct7 = 0) and I-arith; sra picks SRA for funct3 101
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic sra);
    case (f3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b001:  return ALU_SLL;
      3'b101:  return sra ? ALU_SRA : ALU_SRL;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/exec_ctrl_alu_if.sv
// Operand/instruction inputs and registered control/ALU outputs of the execute stage.
interface exec_ctrl_alu_if #(parameter int unsigned XLEN = 64);
  logic [6:0]      opcode;
  logic [9:0]      funct;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            branch;
  logic            mem_read;
  logic            mem_reg;
  logic            mem_write;
  logic            alu_src;
  logic            reg_write;
  logic [1:0]      alu_op;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] remainder;
  logic            zero;

  modport master (
    output opcode, funct, rs1_data, rs2_data, imm,
    input  branch, mem_read, mem_reg, mem_write, alu_src, reg_write,
           alu_op, alu_ctrl, result, remainder, zero
  );

  modport slave (
    input  opcode, funct, rs1_data, rs2_data, imm,
    output branch, mem_read, mem_reg, mem_write, alu_src, reg_write,
           alu_op, alu_ctrl, result, remainder, zero
  );
endinterface

// File: rtl/exec_ctrl_alu_alu_core.sv
// Combinational 64-bit ALU; MUL/DIV/REM datapath only when ALU_MULDIV_EN is defined.
module alu_core
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] remainder,
  output logic            zero
);

  logic [5:0] w_shamt;
  assign w_shamt = b[5:0];

`ifdef ALU_MULDIV_EN
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;

  // Divide-by-zero and signed overflow are resolved explicitly instead of relying on '/'
  always_comb begin
    w_quot = '0;
    w_rem  = '0;
    if (b == '0) begin
      w_quot = '1;
      w_rem  = a;
    end else if (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      w_quot = a;
      w_rem  = '0;
    end else begin
      w_quot = $signed(a) / $signed(b);
      w_rem  = $signed(a) % $signed(b);
    end
  end
`endif

  always_comb begin
    result    = a + b;
    remainder = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << w_shamt;
      ALU_SRL: result = a >> w_shamt;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SRA: result = $unsigned($signed(a) >>> w_shamt);
`ifdef ALU_MULDIV_EN
      ALU_MUL: result = a * b;
      ALU_DIV: begin
        result    = w_quot;
        remainder = w_rem;
      end
      ALU_REM: begin
        result    = w_rem;
        remainder = w_rem;
      end
`endif
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_ctrl_alu.sv
// Execute stage: main decode, ALU-control decode and ALU, all outputs registered.
// Optional MUL/DIV/REM support via macro ALU_MULDIV_EN.
module exec_ctrl_alu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input logic            clk,
  input logic            rst,
  exec_ctrl_alu_if.slave bus
);

  logic       w_branch, w_mem_read, w_mem_reg, w_mem_write, w_alu_src, w_reg_write;
  alu_op_e    w_alu_op;
  logic [3:0] w_alu_ctrl;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic [XLEN-1:0] w_b, w_result, w_remainder;
  logic       w_zero;

  assign w_funct7 = bus.funct[9:3];
  assign w_funct3 = bus.funct[2:0];

  always_comb begin
    w_branch    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_reg   = 1'b0;
    w_mem_write = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_alu_op    = ALUOP_MEM;
    case (bus.opcode)
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_R;
      end
      OP_IARITH: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_I;
      end
      OP_LOAD: begin
        w_alu_src   = 1'b1;
        w_mem_reg   = 1'b1;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
      end
      OP_STORE: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        w_branch = 1'b1;
        w_alu_op = ALUOP_BR;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_alu_op)
      ALUOP_BR: w_alu_ctrl = ALU_SUB;
      ALUOP_R: begin
        case (w_funct7)
          7'b0000000: w_alu_ctrl = arith_ctrl(w_funct3, 1'b0);
          7'b0100000: begin
            if (w_funct3 == 3'b000)      w_alu_ctrl = ALU_SUB;
            else if (w_funct3 == 3'b101) w_alu_ctrl = ALU_SRA;
          end
`ifdef ALU_MULDIV_EN
          7'b0000001: begin
            if (w_funct3 == 3'b000)      w_alu_ctrl = ALU_MUL;
            else if (w_funct3 == 3'b100) w_alu_ctrl = ALU_DIV;
            else if (w_funct3 == 3'b110) w_alu_ctrl = ALU_REM;
          end
`endif
          default: ;
        endcase
      end
      ALUOP_I: w_alu_ctrl = arith_ctrl(w_funct3, w_funct7[5]);
      default: ;
    endcase
  end

  assign w_b = w_alu_src ? bus.imm : bus.rs2_data;

  alu_core #(.XLEN(XLEN)) u_alu (
    .a         (bus.rs1_data),
    .b         (w_b),
    .ctrl      (w_alu_ctrl),
    .result    (w_result),
    .remainder (w_remainder),
    .zero      (w_zero)
  );

  logic       r_branch, r_mem_read, r_mem_reg, r_mem_write, r_alu_src, r_reg_write;
  logic [1:0] r_alu_op;
  logic [3:0] r_alu_ctrl;
  logic [XLEN-1:0] r_result, r_remainder;
  logic       r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_reg   <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= '0;
      r_alu_ctrl  <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_zero      <= 1'b0;
    end else begin
      r_branch    <= w_branch;
      r_mem_read  <= w_mem_read;
      r_mem_reg   <= w_mem_reg;
      r_mem_write <= w_mem_write;
      r_alu_src   <= w_alu_src;
      r_reg_write <= w_reg_write;
      r_alu_op    <= w_alu_op;
      r_alu_ctrl  <= w_alu_ctrl;
      r_result    <= w_result;
      r_remainder <= w_remainder;
      r_zero      <= w_zero;
    end
  end

  assign bus.branch    = r_branch;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_reg   = r_mem_reg;
  assign bus.mem_write = r_mem_write;
  assign bus.alu_src   = r_alu_src;
  assign bus.reg_write = r_reg_write;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.result    = r_result;
  assign bus.remainder = r_remainder;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_exec_ctrl_alu.sv
// Scoreboard bench for exec_ctrl_alu: directed plan vectors plus random instructions vs a mnemonic-level model.
module tb_exec_ctrl_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_ctrl_alu_if #(.XLEN(64)) bus ();

  exec_ctrl_alu #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        branch, mem_read, mem_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [63:0] result, remainder;
    logic        zero;
  } exp_t;

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SLT,
                M_MUL, M_DIV, M_REM} mnem_e;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic mnem_e base_op(input bit [2:0] f3);
    case (f3)
      3'd0: return M_ADD;
      3'd7: return M_AND;
      3'd6: return M_OR;
      3'd4: return M_XOR;
      3'd1: return M_SLL;
      3'd5: return M_SRL;
      3'd2: return M_SLT;
      default: return M_ADD;
    endcase
  endfunction

  function automatic bit [3:0] op_code(input mnem_e m);
    case (m)
      M_AND: return 4'd0;
      M_OR:  return 4'd1;
      M_ADD: return 4'd2;
      M_XOR: return 4'd3;
      M_SLL: return 4'd4;
      M_SRL: return 4'd5;
      M_SUB: return 4'd6;
      M_SLT: return 4'd7;
      M_SRA: return 4'd8;
      M_MUL: return 4'd9;
      M_DIV: return 4'd10;
      M_REM: return 4'd11;
      default: return 4'd2;
    endcase
  endfunction

  function automatic exp_t model(input bit r, input bit [6:0] op, input bit [9:0] fn,
                                 input bit [63:0] a, input bit [63:0] rs2, input bit [63:0] im);
    exp_t e;
    mnem_e m;
    bit [63:0] b, q, rm;
    longint sa, sb2;
    bit [6:0] f7;
    bit [2:0] f3;
    e = '0;
    if (r) return e;
    f7 = fn[9:3];
    f3 = fn[2:0];
    case (op)
      7'b0110011: begin e.reg_write = 1; e.alu_op = 2'b10; end
      7'b0010011: begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'b11; end
      7'b0000011: begin e.alu_src = 1; e.mem_reg = 1; e.reg_write = 1; e.mem_read = 1; end
      7'b0100011: begin e.alu_src = 1; e.mem_write = 1; end
      7'b1100011: begin e.branch = 1; e.alu_op = 2'b01; end
      default: ;
    endcase
    b = e.alu_src ? im : rs2;
    m = M_ADD;
    if (e.alu_op == 2'b01) m = M_SUB;
    else if (e.alu_op == 2'b10) begin
      if (f7 == 7'h00) m = base_op(f3);
      else if (f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) m = M_SRA;
`ifdef ALU_MULDIV_EN
      else if (f7 == 7'h01 && f3 == 3'd0) m = M_MUL;
      else if (f7 == 7'h01 && f3 == 3'd4) m = M_DIV;
      else if (f7 == 7'h01 && f3 == 3'd6) m = M_REM;
`endif
    end else if (e.alu_op == 2'b11) begin
      m = base_op(f3);
      if (m == M_SRL && f7[5]) m = M_SRA;
    end
    e.alu_ctrl = op_code(m);
    sa  = a;
    sb2 = b;
    case (m)
      M_ADD: e.result = a + b;
      M_SUB: e.result = a - b;
      M_AND: e.result = a & b;
      M_OR:  e.result = a | b;
      M_XOR: e.result = a ^ b;
      M_SLL: e.result = a << b[5:0];
      M_SRL: e.result = a >> b[5:0];
      M_SRA: e.result = sa >>> b[5:0];
      M_SLT: e.result = (sa < sb2) ? 64'd1 : 64'd0;
      M_MUL: e.result = a * b;
      default: begin
        if (sb2 == 0) begin
          q = '1; rm = a;
        end else if (a == 64'h8000_0000_0000_0000 && sb2 == -1) begin
          q = a; rm = 0;
        end else begin
          q = sa / sb2; rm = sa % sb2;
        end
        e.result    = (m == M_DIV) ? q : rm;
        e.remainder = rm;
      end
    endcase
    e.zero = (e.result == 64'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [6:0] op, input bit [9:0] fn,
                       input bit [63:0] a, input bit [63:0] b, input bit [63:0] im);
    @(negedge clk);
    rst          = r;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.imm      = im;
    sb.push_back(model(r, op, fn, a, b, im));
  endtask

  function automatic bit [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: DUT outputs for the item pushed before a rising edge are checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("branch",    64'(bus.branch),    64'(e.branch));
        chk("mem_read",  64'(bus.mem_read),  64'(e.mem_read));
        chk("mem_reg",   64'(bus.mem_reg),   64'(e.mem_reg));
        chk("mem_write", 64'(bus.mem_write), 64'(e.mem_write));
        chk("alu_src",   64'(bus.alu_src),   64'(e.alu_src));
        chk("reg_write", 64'(bus.reg_write), 64'(e.reg_write));
        chk("alu_op",    64'(bus.alu_op),    64'(e.alu_op));
        chk("alu_ctrl",  64'(bus.alu_ctrl),  64'(e.alu_ctrl));
        chk("result",    bus.result,         e.result);
        chk("remainder", bus.remainder,      e.remainder);
        chk("zero",      64'(bus.zero),      64'(e.zero));
      end
    end
  end

  initial begin
    bit [6:0] ops [6];
    bit [6:0] f7s [4];
    bit [6:0] op, f7;
    int waited;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};

    drive(1, 7'b0110011, 10'h3ff, 64'h1234, 64'h5678, 64'h9);
    drive(1, 7'b0000011, 10'h000, '1, '1, '1);

    drive(0, 7'b0110011, {7'h00, 3'd0}, 64'd5, 64'd7, 64'd0);
    drive(0, 7'b0110011, {7'h20, 3'd0}, 64'd5, 64'd7, 64'd0);
    drive(0, 7'b1100011, {7'h00, 3'd0}, 64'h1234, 64'h1234, 64'd44);
    drive(0, 7'b0000011, {7'h00, 3'd3}, 64'h100, 64'd99, 64'd8);
    drive(0, 7'b0100011, {7'h00, 3'd3}, 64'h100, 64'd99, 64'd8);
    drive(0, 7'b0010011, {7'h20, 3'd5}, 64'h8000_0000_0000_0000, 64'd0, 64'd4);
    drive(0, 7'b0010011, {7'h00, 3'd5}, 64'h8000_0000_0000_0000, 64'd0, 64'd4);
    drive(0, 7'b0110011, {7'h00, 3'd2}, '1, 64'd1, 64'd0);
    drive(0, 7'b0110011, {7'h01, 3'd4}, -64'd7, 64'd2, 64'd0);
    drive(0, 7'b0110011, {7'h01, 3'd4}, -64'd7, 64'd0, 64'd0);
    drive(0, 7'b0110011, {7'h01, 3'd6}, -64'd7, 64'd2, 64'd0);
    drive(0, 7'b0110011, {7'h01, 3'd4}, 64'h8000_0000_0000_0000, '1, 64'd0);
    drive(0, 7'b0110011, {7'h01, 3'd0}, -64'd3, 64'd5, 64'd0);
    drive(0, 7'b1111111, 10'h3ff, 64'd3, 64'd4, 64'd5);
    drive(1, 7'b0110011, {7'h00, 3'd0}, 64'd5, 64'd7, 64'd0);
    drive(0, 7'b0110011, {7'h00, 3'd0}, 64'd5, 64'd7, 64'd0);

    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      f7 = f7s[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
      drive($urandom_range(0, 24) == 0, op, {f7, 3'($urandom)}, rnd64(), rnd64(),
            ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 70)) : rnd64());
    end

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d items left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_alu.md
Name: exec_ctrl_alu

Overview:
- Execute-stage block of the single-cycle RV64 core.
- Merges three functions: the main opcode decoder, the ALU-control decoder and the 64-bit ALU (with remainder output).
- Sits between the register file/immediate generator and data memory/writeback muxes.
- All outputs are registered, giving one cycle of latency.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0]
- funct  in  10  {instruction[31:25], instruction[14:12]}
- rs1_data  in  64  ALU operand A
- rs2_data  in  64  register operand B
- imm  in  64  sign-extended immediate
- branch  out  1  branch instruction
- mem_read  out  1  load
- mem_reg  out  1  writeback selects memory data
- mem_write  out  1  store
- alu_src  out  1  operand B = imm
- reg_write  out  1  register write enable
- alu_op  out  2  decoded ALU class
- alu_ctrl  out  4  ALU operation code
- result  out  64  ALU result
- remainder  out  64  division remainder
- zero  out  1  result == 0

Behaviour:
- Reset: on a rising clk with rst=1, every output register clears to 0, including zero.
- Normal operation: each rising clk with rst=0 registers the outputs computed from the current inputs. Latency is exactly 1 cycle, with no handshake and no stall.
- Main decode (alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op):
  - 0110011 R-type: 0,0,1,0,0,0,10
  - 0010011 I-arith: 1,0,1,0,0,0,11
  - 0000011 load: 1,1,1,1,0,0,00
  - 0100011 store: 1,0,0,0,1,0,00
  - 1100011 branch: 0,0,0,0,0,1,01
  - any other opcode: all 0, alu_op=00
- Operand B: B = alu_src ? imm : rs2_data, muxed internally.
- alu_ctrl for alu_op 00 and 01: 00 -> ADD 0010; 01 -> SUB 0110.
- alu_ctrl for alu_op 10 (R-type), keyed on funct7/funct3:
  - 0000000: 000 ADD, 111 AND 0000, 110 OR 0001, 100 XOR 0011, 001 SLL 0100, 101 SRL 0101, 010 SLT 0111
  - 0100000: 000 SUB, 101 SRA 1000
  - 0000001: 000 MUL 1001, 100 DIV 1010, 110 REM 1011
  - all other combinations: ADD
- alu_ctrl for alu_op 11 (I-arith): keyed on funct3 alone with the same map. For funct3 101, funct7[5] selects SRA over SRL.
- ALU arithmetic:
  - Modulo-2^64, with no overflow/carry outputs.
  - SLT is signed and returns 0 or 1.
  - Shifts use B[5:0].
  - MUL returns the low 64 bits of the signed product.
- DIV/REM (both signed):
  - DIV: result = quotient, remainder = remainder.
  - REM: result = remainder, remainder = remainder.
  - Remainder takes the sign of the dividend.
  - Divide by zero: quotient = all-ones, remainder = A.
  - Overflow (A = -2^63, B = -1): quotient = A, remainder = 0.
  - For non-divide operations, remainder = 0.
- zero is computed from the final result value, so a branch uses the SUB result.
- Reset mid-stream: the following cycle's outputs are 0 regardless of inputs. The first valid outputs appear one cycle after rst deasserts.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: the MUL/DIV/REM codes and their datapath are present.
- Undefined: funct7 0000001 decodes to ADD, and the remainder output is tied to 0.

Decomposition:
- Package exec_pkg holds:
  - opcode constants
  - alu_op encodings (00/01/10/11)
  - the 4-bit alu_ctrl code localparams
- One sub-module, alu_core: purely combinational 64-bit ALU with inputs a, b, ctrl and outputs result, remainder, zero.
- Decoders and output registers stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all outputs 0. Release -> first decoded outputs appear 1 cycle later.
- R-type ADD/SUB: opcode 0110011, funct 0000000_000, rs1=5, rs2=7 -> result 12, alu_ctrl 0010, reg_write 1. With funct 0100000_000 -> result 0xFFFF_FFFF_FFFF_FFFE, zero 0.
- Branch equal: opcode 1100011, rs1=rs2=0x1234 -> branch 1, alu_op 01, alu_ctrl 0110, result 0, zero 1.
- Load/store: opcode 0000011, rs1=0x100, imm=8 -> result 0x108, mem_read 1, mem_reg 1, alu_src 1. Opcode 0100011 -> mem_write 1, reg_write 0.
- Shifts/SLT: I-arith funct3 101 with funct7 0100000, rs1=0x8000_0000_0000_0000, imm=4 -> result 0xF800_0000_0000_0000. SLT with rs1=-1, rs2=1 -> result 1.
- DIV (ALU_MULDIV_EN defined):
  - A=-7, B=2 -> result -3, remainder -1.
  - B=0 -> result all-ones, remainder -7.
  - Unknown opcode 1111111 -> all control outputs 0.
